// File: rtl/mtp_seq_pkg.sv
// Shared types and defaults for the MTP access sequencer: FSM states,
// default timing constants, strobe bundle and its idle value.
package mtp_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARB,
    S_RD_SETUP,
    S_RD_STROBE,
    S_RD_CAP,
    S_WR_LOAD,
    S_WR_PULSE,
    S_WR_WAIT_LO,
    S_WR_WAIT_HI,
    S_NEXT
  } state_t;

  localparam int N_CH_DEF    = 3;
  localparam int AW_DEF      = 6;
  localparam int DW_DEF      = 16;
  localparam int LW_DEF      = 6;
  localparam int T_SETUP_DEF = 8;
  localparam int T_RDCLK_DEF = 4;
  localparam int T_WEN_DEF   = 2;
  localparam int WR_TMO_DEF  = 1023;

  typedef struct packed {
    logic cen;
    logic oen;
    logic wen;
    logic rd_clk;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{cen: 1'b1, oen: 1'b1, wen: 1'b1, rd_clk: 1'b0};

  // Width of a down/up counter whose largest loaded value is max_val-1.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mtp_seq_arb.sv
// Fixed-priority arbiter: lowest requesting index wins, one-hot grant.
module mtp_seq_arb #(
  parameter int N_CH = 3
) (
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] grant,
  output logic            any
);

  // NOTE: every variable written in always_comb gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mtp_access_seq.sv
// Multi-channel MTP access sequencer: arbitrates burst jobs and drives MTP strobes.
// Optional WR_VERIFY_EN: read back each written word and abort the burst on mismatch.
module mtp_access_seq
  import mtp_seq_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int LW      = LW_DEF,
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_RDCLK = T_RDCLK_DEF,
  parameter int T_WEN   = T_WEN_DEF,
  parameter int WR_TMO  = WR_TMO_DEF
) (
  input  logic              clk_1_92m,
  input  logic              rst_n,
  input  logic              new_cmd,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH-1:0]   req_wr,
  input  logic [N_CH*AW-1:0] req_ptr,
  input  logic [N_CH*LW-1:0] req_len,
  output logic [N_CH-1:0]   ack,
  input  logic [DW-1:0]     wr_data,
  output logic              wr_take,
  output logic [DW-1:0]     rd_data,
  output logic              rd_vld,
  output logic              word_done,
  output logic              job_done,
  output logic              job_err,
  output logic              busy,
  output logic [AW-1:0]     A,
  output logic              CEN,
  output logic              OEN,
  output logic              WEN,
  output logic              RD_CLK,
  output logic [DW-1:0]     DBI,
  input  logic [DW-1:0]     DBO,
  input  logic              READY
);

  localparam int TW    = cnt_width(max3(T_SETUP, T_RDCLK, T_WEN));
  localparam int TMO_W = cnt_width(WR_TMO);

  state_t             state;
  strobe_t            strb;
  logic               wr_q;
  logic [AW-1:0]      ptr_q;
  logic [LW-1:0]      len_q;
  logic [LW-1:0]      wcnt;
  logic [TW-1:0]      tcnt;
  logic [TMO_W-1:0]   tmo;
  logic [DW-1:0]      wr_reg;

  logic [N_CH-1:0]    grant;
  logic               any;
  logic               sel_wr;
  logic [AW-1:0]      sel_ptr;
  logic [LW-1:0]      sel_len;
  logic [AW-1:0]      addr_nxt;
  logic [LW-1:0]      wcnt_inc;
  logic               last_word;
  logic               tmo_hit;

  mtp_seq_arb #(.N_CH(N_CH)) u_arb (
    .req   (req),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    sel_wr  = 1'b0;
    sel_ptr = '0;
    sel_len = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        sel_wr  = req_wr[i];
        sel_ptr = req_ptr[i*AW +: AW];
        sel_len = req_len[i*LW +: LW];
      end
    end
  end

  // Address wraps naturally at AW bits (2^AW-1 -> 0).
  assign addr_nxt  = ptr_q + AW'(wcnt);
  assign wcnt_inc  = wcnt + 1'b1;
  assign last_word = (wcnt_inc == len_q) || (len_q == '0);
  assign tmo_hit   = (tmo == TMO_W'(WR_TMO - 1));

  assign CEN    = strb.cen;
  assign OEN    = strb.oen;
  assign WEN    = strb.wen;
  assign RD_CLK = strb.rd_clk;
  assign DBI    = wr_reg;

  // NOTE: state and outputs use non-blocking assignments only, so every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk_1_92m) begin
    if (!rst_n) begin
      // NOTE: these are a handful of flops, not a memory array, so all of
      // them (data registers included) are reset to known values.
      state     <= S_IDLE;
      strb      <= STROBE_IDLE;
      A         <= '0;
      ack       <= '0;
      wr_take   <= 1'b0;
      rd_data   <= '0;
      rd_vld    <= 1'b0;
      word_done <= 1'b0;
      job_done  <= 1'b0;
      job_err   <= 1'b0;
      busy      <= 1'b0;
      wr_q      <= 1'b0;
      ptr_q     <= '0;
      len_q     <= '0;
      wcnt      <= '0;
      tcnt      <= '0;
      tmo       <= '0;
      wr_reg    <= '0;
    end else begin
      ack       <= '0;
      wr_take   <= 1'b0;
      rd_vld    <= 1'b0;
      word_done <= 1'b0;
      job_done  <= 1'b0;
      job_err   <= 1'b0;

      if (new_cmd) begin
        strb  <= STROBE_IDLE;
        busy  <= 1'b0;
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            busy <= any;
            if (any) begin
              ack   <= grant;
              wr_q  <= sel_wr;
              ptr_q <= sel_ptr;
              len_q <= sel_len;
              wcnt  <= '0;
              state <= (sel_len == '0) ? S_NEXT : S_ARB;
            end
          end

          S_ARB: begin
            A        <= addr_nxt;
            strb.cen <= 1'b0;
            if (wr_q) begin
              wr_take <= 1'b1;
              state   <= S_WR_LOAD;
            end else begin
              strb.oen <= 1'b0;
              tcnt     <= TW'(T_SETUP - 1);
              state    <= S_RD_SETUP;
            end
          end

          S_RD_SETUP: begin
            if (tcnt == '0) begin
              strb.rd_clk <= 1'b1;
              tcnt        <= TW'(T_RDCLK - 1);
              state       <= S_RD_STROBE;
            end else begin
              tcnt <= tcnt - 1'b1;
            end
          end

          S_RD_STROBE: begin
            if (tcnt != '0) begin
              tcnt <= tcnt - 1'b1;
            end else begin
              strb.rd_clk <= 1'b0;
`ifdef WR_VERIFY_EN
              if (wr_q) begin
                strb.oen <= 1'b1;
                if (DBO != wr_reg) begin
                  strb     <= STROBE_IDLE;
                  job_err  <= 1'b1;
                  job_done <= 1'b1;
                  state    <= S_IDLE;
                end else begin
                  word_done <= 1'b1;
                  state     <= S_RD_CAP;
                end
              end else begin
                rd_data   <= DBO;
                rd_vld    <= 1'b1;
                word_done <= 1'b1;
                state     <= S_RD_CAP;
              end
`else
              rd_data   <= DBO;
              rd_vld    <= 1'b1;
              word_done <= 1'b1;
              state     <= S_RD_CAP;
`endif
            end
          end

          S_RD_CAP: state <= S_NEXT;

          S_WR_LOAD: begin
            wr_reg   <= wr_data;
            strb.wen <= 1'b0;
            tcnt     <= TW'(T_WEN - 1);
            state    <= S_WR_PULSE;
          end

          S_WR_PULSE: begin
            if (tcnt == '0) begin
              strb.wen <= 1'b1;
              tmo      <= '0;
              state    <= S_WR_WAIT_LO;
            end else begin
              tcnt <= tcnt - 1'b1;
            end
          end

          // One timeout budget covers both the READY fall and its return.
          S_WR_WAIT_LO, S_WR_WAIT_HI: begin
            if (tmo_hit) begin
              strb     <= STROBE_IDLE;
              job_err  <= 1'b1;
              job_done <= 1'b1;
              state    <= S_IDLE;
            end else begin
              tmo <= tmo + 1'b1;
              if (state == S_WR_WAIT_LO && !READY) begin
                state <= S_WR_WAIT_HI;
              end else if (state == S_WR_WAIT_HI && READY) begin
`ifdef WR_VERIFY_EN
                strb.oen <= 1'b0;
                tcnt     <= TW'(T_SETUP - 1);
                state    <= S_RD_SETUP;
`else
                word_done <= 1'b1;
                state     <= S_NEXT;
`endif
              end
            end
          end

          S_NEXT: begin
            wcnt <= wcnt_inc;
            if (last_word) begin
              strb     <= STROBE_IDLE;
              job_done <= 1'b1;
              state    <= S_IDLE;
            end else begin
              state <= S_ARB;
            end
          end

          default: begin
            strb  <= STROBE_IDLE;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
